// File: rtl/audio_ctrl_pkg.sv
// Shared definitions for the audio codec reset sequencer.
//   - seq_state_e : sequencer FSM states
//   - PIO_LEVEL_* : level written to the codec reset PIO (0 holds the codec in reset)
//   - AVM_DATA_W  : Avalon-MM data bus width
//   - max_int     : helper for sizing counters from parameters
package audio_ctrl_pkg;

  localparam int   AVM_DATA_W        = 32;
  localparam logic PIO_LEVEL_ASSERT  = 1'b0;
  localparam logic PIO_LEVEL_RELEASE = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    WR_LOW,
    HOLD,
    WR_HIGH,
    SETTLE,
    RD_REQ,
    RD_WAIT,
    FINISH_OK,
    FINISH_ERR
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/avm_single_xfer.sv
// Single Avalon-MM transfer engine: issues one write or one read to a fixed
// word address and reports how it ended.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   launch_wr, launch_rd  one-cycle request; the strobe is high from the next edge
//   wr_level              reset level carried in writedata bit 0
//   avm_*                 Avalon-MM master signals
//   wr_ok                 write accepted this cycle
//   rd_accept             read command accepted this cycle
//   rd_ok                 read data captured in rd_data (one cycle after readdatavalid)
//   rd_data               captured readdata
//   timeout               stall limit reached this cycle; strobes drop on the next edge
module avm_single_xfer
  import audio_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [1:0] PIO_ADDR       = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  launch_wr,
  input  logic                  launch_rd,
  input  logic                  wr_level,
  output logic [1:0]            avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [AVM_DATA_W-1:0] avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  wr_ok,
  output logic                  rd_accept,
  output logic                  rd_ok,
  output logic [AVM_DATA_W-1:0] rd_data,
  output logic                  timeout
);

  localparam int               STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic                  wait_q, wait_d;
  logic                  wlevel_q, wlevel_d;
  logic                  rd_ok_q, rd_ok_d;
  logic [AVM_DATA_W-1:0] rd_data_q, rd_data_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic                  stalling;

  always_comb begin
    stalling  = ((write_q | read_q) & avm_waitrequest) | (wait_q & ~avm_readdatavalid);
    timeout   = stalling & (stall_q == STALL_LAST);
    wr_ok     = write_q & ~avm_waitrequest;
    rd_accept = read_q & ~avm_waitrequest;

    write_d   = launch_wr | (write_q & avm_waitrequest & ~timeout);
    read_d    = launch_rd | (read_q & avm_waitrequest & ~timeout);
    wait_d    = rd_accept | (wait_q & ~avm_readdatavalid & ~timeout);
    wlevel_d  = launch_wr ? wr_level : wlevel_q;
    // Data is captured before the sequencer looks at it, so the off-block
    // readdata path ends in a flop rather than in FSM decode.
    rd_ok_d   = wait_q & avm_readdatavalid;
    rd_data_d = rd_ok_d ? avm_readdata : rd_data_q;

    stall_d = stall_q;
    if (launch_wr | launch_rd | rd_accept | timeout) begin
      stall_d = '0;
    end else if (stalling) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      wait_q    <= 1'b0;
      wlevel_q  <= 1'b0;
      rd_ok_q   <= 1'b0;
      rd_data_q <= '0;
      stall_q   <= '0;
    end else begin
      write_q   <= write_d;
      read_q    <= read_d;
      wait_q    <= wait_d;
      wlevel_q  <= wlevel_d;
      rd_ok_q   <= rd_ok_d;
      rd_data_q <= rd_data_d;
      stall_q   <= stall_d;
    end
  end

  assign avm_address   = PIO_ADDR;
  assign avm_write     = write_q;
  assign avm_read      = read_q;
  assign avm_writedata = {{(AVM_DATA_W-1){1'b0}}, wlevel_q};
  assign rd_ok         = rd_ok_q;
  assign rd_data       = rd_data_q;

endmodule

// File: rtl/audio_reset_pio_sequencer.sv
// Codec reset sequencer: drives the audio PIO reset line low, holds it,
// releases it, waits for the codec to settle and reads the PIO back.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   start            one-cycle run request, ignored while busy
//   busy             sequence in progress
//   done, error      sticky result flags, cleared by the next accepted start
//   avm_*            Avalon-MM master to the PIO slave
//
// state      | meaning
// IDLE       | waiting for start
// WR_LOW     | writing 0 (codec held in reset)
// HOLD       | holding reset for HOLD_CYCLES
// WR_HIGH    | writing 1 (codec released)
// SETTLE     | waiting SETTLE_CYCLES for the codec
// RD_REQ     | read command outstanding
// RD_WAIT    | waiting for read data
// FINISH_OK  | raising done
// FINISH_ERR | raising error
module audio_reset_pio_sequencer
  import audio_ctrl_pkg::*;
#(
  parameter int         HOLD_CYCLES    = 1000,
  parameter int         SETTLE_CYCLES  = 5000,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [1:0] PIO_ADDR       = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [AVM_DATA_W-1:0] avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int                 CNT_W       = $clog2(max_int(HOLD_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  launch_wr, launch_rd, launch_level;
  logic                  wr_ok, rd_accept, rd_ok, timeout;
  logic [AVM_DATA_W-1:0] rd_data;
  logic                  unused_rd_hi;

  // Only bit 0 of the readback carries the reset level.
  assign unused_rd_hi = ^rd_data[AVM_DATA_W-1:1];

  avm_single_xfer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .PIO_ADDR       (PIO_ADDR)
  ) u_xfer (
    .clk               (clk),
    .reset_n           (reset_n),
    .launch_wr         (launch_wr),
    .launch_rd         (launch_rd),
    .wr_level          (launch_level),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .wr_ok             (wr_ok),
    .rd_accept         (rd_accept),
    .rd_ok             (rd_ok),
    .rd_data           (rd_data),
    .timeout           (timeout)
  );

  // Launches are decided alongside the state change so the strobe flop
  // rises on the same edge the FSM enters the transfer state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    launch_wr    = 1'b0;
    launch_rd    = 1'b0;
    launch_level = PIO_LEVEL_ASSERT;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = WR_LOW;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          launch_wr    = 1'b1;
          launch_level = PIO_LEVEL_ASSERT;
        end
      end
      WR_LOW: begin
        if (timeout) begin
          state_d = FINISH_ERR;
        end else if (wr_ok) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d      = WR_HIGH;
          launch_wr    = 1'b1;
          launch_level = PIO_LEVEL_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_HIGH: begin
        if (timeout) begin
          state_d = FINISH_ERR;
        end else if (wr_ok) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d   = RD_REQ;
          launch_rd = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_REQ: begin
        if (timeout) begin
          state_d = FINISH_ERR;
        end else if (rd_accept) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (timeout) begin
          state_d = FINISH_ERR;
        end else if (rd_ok) begin
          state_d = (rd_data[0] == PIO_LEVEL_RELEASE) ? FINISH_OK : FINISH_ERR;
        end
      end
      FINISH_OK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      FINISH_ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_audio_reset_pio_sequencer.sv
module tb_audio_reset_pio_sequencer;

  localparam int HOLD   = 4;
  localparam int SETTLE = 6;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [1:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;

  audio_reset_pio_sequencer #(
    .HOLD_CYCLES    (HOLD),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .PIO_ADDR       (2'd0)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model knobs (written by the test) and observations (written by the slave)
  int          ws_cfg = 0;
  logic [31:0] rd_value = 32'h1;
  int          stuck_wr_idx = -1;
  int          wr_total = 0;
  int          stall_total = 0;
  int          both_hi = 0;
  int          unstable = 0;
  logic [1:0]  log_addr[$];
  logic [31:0] log_data[$];
  bit          log_is_wr[$];
  int          log_cyc[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Avalon slave: samples transfers at negedge, drives responses #1 after posedge.
  initial begin : slave
    int         sc;
    bit         rd_acc;
    bit         prev_stall;
    logic [1:0] prev_addr;
    logic [31:0] prev_data;
    logic       prev_wr;
    sc = 0; rd_acc = 0; prev_stall = 0; prev_addr = 0; prev_data = 0; prev_wr = 0;
    forever begin
      @(negedge clk);
      rd_acc = 0;
      if (!reset_n) begin
        prev_stall = 0;
        sc = 0;
      end else begin
        if (avm_write && avm_read) both_hi++;
        if (prev_stall && (avm_write || avm_read) &&
            (avm_address != prev_addr || avm_writedata != prev_data || avm_write != prev_wr))
          unstable++;
        if ((avm_write || avm_read) && !avm_waitrequest) begin
          log_addr.push_back(avm_address);
          log_data.push_back(avm_writedata);
          log_is_wr.push_back(avm_write);
          log_cyc.push_back(cyc);
          if (avm_write) wr_total++;
          rd_acc = avm_read;
          sc = 0;
          prev_stall = 0;
        end else if (avm_write || avm_read) begin
          stall_total++;
          prev_stall = 1;
          prev_addr = avm_address;
          prev_data = avm_writedata;
          prev_wr = avm_write;
        end else begin
          prev_stall = 0;
        end
      end
      @(posedge clk);
      #1;
      avm_readdatavalid = rd_acc;
      avm_readdata = rd_acc ? rd_value : 32'h0;
      if (avm_write || avm_read) begin
        if (avm_write && stuck_wr_idx == wr_total) avm_waitrequest = 1'b1;
        else if (sc < ws_cfg) begin
          avm_waitrequest = 1'b1;
          sc++;
        end else avm_waitrequest = 1'b0;
      end else begin
        avm_waitrequest = 1'b0;
        sc = 0;
      end
    end
  end

  typedef struct {
    int          ws;
    logic [31:0] rd_value;
    bit          stuck;
    bit          exp_done;
    bit          exp_error;
    int          exp_lat;
    int          exp_xfers;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[7];

  task automatic run_row(input int r);
    int base, sbase, n;
    ws_cfg   = vecs[r].ws;
    rd_value = vecs[r].rd_value;
    base     = log_data.size();
    sbase    = stall_total;
    stuck_wr_idx = vecs[r].stuck ? wr_total + 1 : -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("row%0d busy_at_start", r), busy, 1);
    chk($sformatf("row%0d done_cleared", r), done, 0);
    chk($sformatf("row%0d error_cleared", r), error, 0);
    n = 1;
    while (!(done || error) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("row%0d latency", r), n, vecs[r].exp_lat);
    chk($sformatf("row%0d done", r), done, vecs[r].exp_done);
    chk($sformatf("row%0d error", r), error, vecs[r].exp_error);
    chk($sformatf("row%0d busy_end", r), busy, 0);
    chk($sformatf("row%0d strobes_idle", r), {avm_write, avm_read}, 0);
    chk($sformatf("row%0d xfers", r), log_data.size() - base, vecs[r].exp_xfers);
    chk($sformatf("row%0d stall_cycles", r), stall_total - sbase, vecs[r].exp_stalls);
    if (vecs[r].exp_xfers == 3 && log_data.size() >= base + 3) begin
      chk($sformatf("row%0d kinds", r),
          {log_is_wr[base], log_is_wr[base+1], log_is_wr[base+2]}, 3'b110);
      chk($sformatf("row%0d wdata0", r), log_data[base], 32'h0);
      chk($sformatf("row%0d wdata1", r), log_data[base+1], 32'h1);
      chk($sformatf("row%0d addrs", r),
          {log_addr[base], log_addr[base+1], log_addr[base+2]}, 6'b0);
      chk($sformatf("row%0d hold_gap", r), log_cyc[base+1] - log_cyc[base], 5 + vecs[r].ws);
      chk($sformatf("row%0d settle_gap", r), log_cyc[base+2] - log_cyc[base+1], 7 + vecs[r].ws);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, n;
    //          ws  readdata      stk done err lat xf stalls
    vecs[0] = '{0, 32'h0000_0001, 0,  1,   0,  17, 3, 0};
    vecs[1] = '{3, 32'h0000_0001, 0,  1,   0,  26, 3, 9};
    vecs[2] = '{0, 32'h0000_0000, 0,  0,   1,  17, 3, 0};
    vecs[3] = '{0, 32'hFFFF_FFFE, 0,  0,   1,  17, 3, 0};
    vecs[4] = '{0, 32'h0000_0003, 0,  1,   0,  17, 3, 0};
    vecs[5] = '{0, 32'h0000_0001, 1,  0,   1,  15, 1, 8};
    vecs[6] = '{0, 32'h0000_0001, 0,  1,   0,  17, 3, 0};

    repeat (3) @(negedge clk);
    chk("reset_flags", {busy, done, error}, 3'b000);
    chk("reset_strobes", {avm_write, avm_read}, 2'b00);
    chk("reset_wdata", avm_writedata, 32'h0);
    chk("reset_addr", avm_address, 2'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 7; r++) run_row(r);

    // reset asserted while the line is being held low
    ws_cfg = 0;
    rd_value = 32'h1;
    stuck_wr_idx = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_busy_before_reset", busy, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_flags", {busy, done, error}, 3'b000);
    chk("midreset_strobes", {avm_write, avm_read}, 2'b00);
    chk("midreset_wdata", avm_writedata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // start held high for the whole run, including the FINISH cycle
    base = log_data.size();
    start = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    while (!(done || error) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("spam_latency", n, 17);
    chk("spam_done", {done, error}, 2'b10);
    repeat (20) @(posedge clk);
    #1;
    chk("spam_xfers", log_data.size() - base, 3);
    chk("spam_busy_after", busy, 0);
    chk("spam_done_sticky", done, 1);

    chk("never_read_and_write", both_hi, 0);
    chk("stable_under_wait", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
